// File: rtl/cpu_dbg_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and halt causes.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } run_state_t;

  typedef enum logic [1:0] {
    HALT_NONE = 2'd0,
    HALT_CYC  = 2'd1,
    HALT_END  = 2'd2,
    HALT_LOOP = 2'd3
  } halt_reason_t;

  function automatic logic is_busy(input run_state_t s);
    return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_DUMP);
  endfunction

endpackage

// File: rtl/cpu_halt_detect.sv
// Halt detection while the CPU runs: cycle limit, PC past the loaded program
// (after a drain window), or PC parked on one address.
module cpu_halt_detect
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IADDR_W    = 7,
  parameter int MAX_CYCLES = 1024,
  parameter int DRAIN      = 5,
  parameter int LOOP_LIMIT = 8,
  parameter int CYC_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DATA_W-1:0]  cpu_pc,
  input  logic [IADDR_W:0]   word_count,
  input  logic [CYC_W-1:0]   cycles,
  output logic               halt,
  output halt_reason_t       reason
);

  localparam int DCW = $clog2(DRAIN + 1);
  localparam int LCW = $clog2(LOOP_LIMIT + 1);
  localparam logic [DCW-1:0]   DRAIN_N  = DCW'(DRAIN);
  localparam logic [LCW-1:0]   LOOP_N   = LCW'(LOOP_LIMIT);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);

  logic [DCW-1:0]    drain_cnt, drain_len;
  logic [LCW-1:0]    same_cnt, same_len;
  logic [DATA_W-1:0] prev_pc;
  logic              have_prev;
  logic [IADDR_W:0]  pc_word;
  logic              past_end, hit_cyc, hit_end, hit_loop;

  // The *_len values include the current cycle, so a halt is flagged on the
  // very cycle the run of past-end / unchanged PCs reaches its limit.
  always_comb begin
    pc_word   = {1'b0, cpu_pc[IADDR_W+1:2]};
    past_end  = (pc_word >= word_count);
    drain_len = '0;
    if (past_end) begin
      drain_len = (drain_cnt == DRAIN_N) ? DRAIN_N : drain_cnt + 1'b1;
    end
    same_len = LCW'(1);
    if (have_prev && (cpu_pc == prev_pc)) begin
      same_len = (same_cnt == LOOP_N) ? LOOP_N : same_cnt + 1'b1;
    end
    hit_cyc  = (cycles >= LAST_CYC);
    hit_end  = (drain_len >= DRAIN_N);
    hit_loop = (same_len >= LOOP_N);
    halt     = run && (hit_cyc || hit_end || hit_loop);
    reason   = HALT_NONE;
    if (run) begin
      if (hit_cyc)       reason = HALT_CYC;
      else if (hit_end)  reason = HALT_END;
      else if (hit_loop) reason = HALT_LOOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      drain_cnt <= '0;
      same_cnt  <= '0;
      prev_pc   <= '0;
      have_prev <= 1'b0;
    end else begin
      drain_cnt <= drain_len;
      same_cnt  <= same_len;
      prev_pc   <= cpu_pc;
      have_prev <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined MIPS CPU: load program, run until halt,
// then stream the register file out over a valid/ready channel.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 128,
  parameter int REGS       = 32,
  parameter int MAX_CYCLES = 1024,
  parameter int DRAIN      = 5,
  parameter int LOOP_LIMIT = 8,
  parameter int CYC_W      = 16,
  localparam int IADDR_W   = $clog2(IMEM_DEPTH),
  localparam int REG_AW    = $clog2(REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_rst,
  output logic               cpu_en,
  input  logic [DATA_W-1:0]  cpu_pc,
  output logic [REG_AW-1:0]  dbg_reg_addr,
  input  logic [DATA_W-1:0]  dbg_reg_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [DATA_W-1:0]  dump_data,
  output logic [REG_AW-1:0]  dump_idx,
  output logic               dump_last,
  output logic               busy,
  output logic               done,
  output logic [CYC_W-1:0]   cycles,
  output logic [1:0]         halt_reason,
  output run_state_t         fsm_state
);

  // Both channels use the same rule: a word moves on a cycle where valid and
  // ready are both high; the producer holds data steady while valid & !ready.

  localparam logic [IADDR_W:0]  LAST_ADDR = (IADDR_W + 1)'(IMEM_DEPTH - 1);
  localparam logic [REG_AW-1:0] LAST_REG  = REG_AW'(REGS - 1);
  localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(MAX_CYCLES);

  run_state_t        state, state_next;
  logic [IADDR_W:0]  word_count;
  logic [REG_AW-1:0] dump_ptr;
  logic              xfer, dump_fire, halt;
  halt_reason_t      halt_code, reason_q;

  assign xfer         = load_valid && load_ready;
  assign dump_fire    = dump_valid && dump_ready;
  assign imem_we      = xfer;
  assign imem_addr    = word_count[IADDR_W-1:0];
  assign imem_wdata   = load_data;
  assign dbg_reg_addr = dump_ptr;
  assign dump_idx     = dump_ptr;
  assign dump_data    = dbg_reg_data;
  assign dump_last    = dump_valid && (dump_ptr == LAST_REG);
  assign halt_reason  = reason_q;
  assign fsm_state    = state;

  cpu_halt_detect #(
    .DATA_W     (DATA_W),
    .IADDR_W    (IADDR_W),
    .MAX_CYCLES (MAX_CYCLES),
    .DRAIN      (DRAIN),
    .LOOP_LIMIT (LOOP_LIMIT),
    .CYC_W      (CYC_W)
  ) u_halt (
    .clk        (clk),
    .rst        (rst),
    .run        (state == ST_RUN),
    .cpu_pc     (cpu_pc),
    .word_count (word_count),
    .cycles     (cycles),
    .halt       (halt),
    .reason     (halt_code)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
      ST_LOAD: if (xfer && (load_last || word_count == LAST_ADDR)) state_next = ST_RUN;
      ST_RUN:  if (halt) state_next = ST_DUMP;
      ST_DUMP: if (dump_fire && dump_last) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      load_ready <= 1'b0;
      cpu_rst    <= 1'b1;
      cpu_en     <= 1'b0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      cycles     <= '0;
      reason_q   <= HALT_NONE;
      dump_ptr   <= '0;
    end else begin
      state      <= state_next;
      load_ready <= (state_next == ST_LOAD);
      cpu_rst    <= (state_next == ST_IDLE) || (state_next == ST_LOAD);
      cpu_en     <= (state_next == ST_RUN);
      dump_valid <= (state_next == ST_DUMP);
      busy       <= is_busy(state_next);
      done       <= (state_next == ST_DONE);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            word_count <= '0;
            cycles     <= '0;
            reason_q   <= HALT_NONE;
            dump_ptr   <= '0;
          end
        end
        ST_LOAD: if (xfer) word_count <= word_count + 1'b1;
        ST_RUN: begin
          if (cycles != CYC_LIMIT) cycles <= cycles + 1'b1;
          if (halt) reason_q <= halt_code;
        end
        ST_DUMP: if (dump_fire) dump_ptr <= dump_ptr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: table-driven scenarios, reset corner
// cases and randomized programs checked against a trace-level halt model.
module tb_cpu_run_ctrl;
  import cpu_dbg_pkg::*;

  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 16;
  localparam int REGS       = 32;
  localparam int MAX_CYCLES = 41;
  localparam int DRAIN      = 5;
  localparam int LOOP_LIMIT = 8;
  localparam int CYC_W      = 16;
  localparam int IADDR_W    = 4;
  localparam int REG_AW     = 5;

  logic               clk = 1'b0;
  logic               rst, start, load_valid, load_last, load_ready;
  logic [DATA_W-1:0]  load_data, imem_wdata, cpu_pc, dbg_reg_data, dump_data;
  logic               imem_we, cpu_rst, cpu_en, dump_valid, dump_ready, dump_last;
  logic [IADDR_W-1:0] imem_addr;
  logic [REG_AW-1:0]  dbg_reg_addr, dump_idx;
  logic               busy, done;
  logic [CYC_W-1:0]   cycles;
  logic [1:0]         halt_reason;
  run_state_t         fsm_state;

  logic [DATA_W-1:0] regs [REGS];
  logic [DATA_W-1:0] prog [IMEM_DEPTH + 4];
  logic [DATA_W-1:0] exp_q [$];

  int checks = 0;
  int failures = 0;

  int          cur_wrap, cur_stuck_at;
  logic [31:0] cur_stuck_pc;

  typedef struct {
    int          words;
    bit          use_last;
    int          extra;
    int          wrap;
    int          stuck_at;
    logic [31:0] stuck_pc;
    int          gap;
    int          exp_reason;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [5];

  assign dbg_reg_data = regs[dbg_reg_addr];

  cpu_run_ctrl #(
    .DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH), .REGS(REGS), .MAX_CYCLES(MAX_CYCLES),
    .DRAIN(DRAIN), .LOOP_LIMIT(LOOP_LIMIT), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_pc(cpu_pc),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .dump_last(dump_last),
    .busy(busy), .done(done), .cycles(cycles), .halt_reason(halt_reason),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_at(input int k);
    if (k >= cur_stuck_at) return cur_stuck_pc;
    return 32'(4 * (k % cur_wrap));
  endfunction

  // Halt model over the whole PC trace: a cause fires at cycle k when the
  // window of the last DRAIN (or LOOP_LIMIT) fetches all satisfy its rule.
  function automatic void model_halt(input int words, output int reason, output int cyc);
    reason = 0;
    cyc    = 0;
    for (int k = 0; k < MAX_CYCLES; k++) begin
      bit end_hit;
      bit loop_hit;
      end_hit = (k >= DRAIN - 1);
      for (int j = k - DRAIN + 1; end_hit && j <= k; j++)
        if (int'((pc_at(j) >> 2) % IMEM_DEPTH) < words) end_hit = 0;
      loop_hit = (k >= LOOP_LIMIT - 1);
      for (int j = k - LOOP_LIMIT + 1; loop_hit && j < k; j++)
        if (pc_at(j) != pc_at(k)) loop_hit = 0;
      if (k + 1 >= MAX_CYCLES) begin reason = 1; cyc = k + 1; return; end
      if (end_hit)             begin reason = 2; cyc = k + 1; return; end
      if (loop_hit)            begin reason = 3; cyc = k + 1; return; end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_load();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_prog(input int n, input bit use_last, input int extra, input int gap);
    int acc = 0;
    int tries = 0;
    int expect_n;
    expect_n = (n > IMEM_DEPTH) ? IMEM_DEPTH : n;
    exp_q.delete();
    for (int i = 0; i < expect_n; i++) exp_q.push_back(prog[i]);
    while (exp_q.size() > 0 && tries < 200) begin
      load_valid = ($urandom_range(0, 99) >= gap);
      load_data  = prog[acc];
      load_last  = use_last && (acc == n - 1);
      @(negedge clk);
      if (tries == 0) begin
        check("load_ready", load_ready, 1);
        check("load_cpu_rst", cpu_rst, 1);
        check("load_busy", busy, 1);
        check("load_done", done, 0);
        check("load_cycles", cycles, 0);
        check("load_reason", halt_reason, 0);
      end
      check("imem_we", imem_we, load_valid);
      if (load_valid) begin
        check("imem_addr", imem_addr, acc);
        check("imem_wdata", imem_wdata, exp_q.pop_front());
        acc++;
      end
      tries++;
      step();
    end
    if (exp_q.size() != 0) check("load_timeout", exp_q.size(), 0);
    load_last  = 1'b0;
    load_valid = (extra > 0);
    load_data  = prog[acc];
  endtask

  task automatic run_prog(input int exp_reason, input int exp_cycles, input bit rand_start);
    int bad_en = 0;
    for (int k = 0; k < exp_cycles; k++) begin
      cpu_pc = pc_at(k);
      if (rand_start) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (k == 0) begin
        check("run_entry_en", cpu_en, 1);
        check("run_entry_we", imem_we, 0);
        check("run_load_ready", load_ready, 0);
        check("run_cpu_rst", cpu_rst, 0);
      end
      if (cpu_en !== 1'b1 || busy !== 1'b1) bad_en++;
      step();
      load_valid = 1'b0;
    end
    start = 1'b0;
    check("run_len", bad_en, 0);
    @(negedge clk);
    check("halt_cpu_en", cpu_en, 0);
    check("halt_dump_valid", dump_valid, 1);
    check("halt_cycles", cycles, exp_cycles);
    check("halt_reason", halt_reason, exp_reason);
    step();
  endtask

  task automatic dump_regs(input int ready_mode, input int exp_reason, input int exp_cycles,
                           input bit rand_start);
    int tries = 0;
    int i = 0;
    int hold_bad = 0;
    int valid_bad = 0;
    bit stalled = 0;
    logic [DATA_W-1:0] held_data;
    logic [REG_AW-1:0] held_idx;
    exp_q.delete();
    for (int r = 0; r < REGS; r++) exp_q.push_back(regs[r]);
    while (exp_q.size() > 0 && tries < 400) begin
      dump_ready = (ready_mode == 0) ? (tries % 2 == 0) : 1'($urandom_range(0, 1));
      if (rand_start) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (stalled && (dump_data !== held_data || dump_idx !== held_idx)) hold_bad++;
      if (dump_valid !== 1'b1 || cpu_en !== 1'b0) valid_bad++;
      if (dump_ready) begin
        check("dump_idx", dump_idx, i);
        check("dump_data", dump_data, exp_q.pop_front());
        check("dump_last", dump_last, (i == REGS - 1));
        i++;
        stalled = 0;
      end else begin
        stalled   = 1;
        held_data = dump_data;
        held_idx  = dump_idx;
      end
      tries++;
      step();
    end
    dump_ready = 1'b0;
    start      = 1'b0;
    check("dump_count", exp_q.size(), 0);
    check("dump_stall_hold", hold_bad, 0);
    check("dump_valid_run", valid_bad, 0);
    @(negedge clk);
    check("done", done, 1);
    check("done_dump_valid", dump_valid, 0);
    check("done_busy", busy, 0);
    check("done_cycles", cycles, exp_cycles);
    check("done_reason", halt_reason, exp_reason);
    step();
  endtask

  task automatic scenario(input vec_t v, input int ready_mode, input bit rand_start);
    cur_wrap     = v.wrap;
    cur_stuck_at = v.stuck_at;
    cur_stuck_pc = v.stuck_pc;
    start_load();
    load_prog(v.words + v.extra, v.use_last, v.extra, v.gap);
    run_prog(v.exp_reason, v.exp_cycles, rand_start);
    dump_regs(ready_mode, v.exp_reason, v.exp_cycles, rand_start);
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_cpu_en"}, cpu_en, 0);
    check({tag, "_load_ready"}, load_ready, 0);
    check({tag, "_dump_valid"}, dump_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cycles"}, cycles, 0);
    check({tag, "_reason"}, halt_reason, 0);
    step();
  endtask

  task automatic randomize_data();
    for (int r = 0; r < REGS; r++) regs[r] = $urandom;
    for (int i = 0; i < IMEM_DEPTH + 4; i++) prog[i] = $urandom;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    int   r_reason, r_cycles;

    vecs[0] = '{words:3,  use_last:1, extra:0, wrap:1000, stuck_at:1000, stuck_pc:32'h0,
                gap:0,  exp_reason:2, exp_cycles:8};
    vecs[1] = '{words:8,  use_last:1, extra:0, wrap:1000, stuck_at:2,    stuck_pc:32'h14,
                gap:30, exp_reason:3, exp_cycles:10};
    vecs[2] = '{words:16, use_last:0, extra:1, wrap:3,    stuck_at:1000, stuck_pc:32'h0,
                gap:20, exp_reason:1, exp_cycles:41};
    vecs[3] = '{words:15, use_last:1, extra:0, wrap:4,    stuck_at:36,   stuck_pc:32'h3c,
                gap:0,  exp_reason:1, exp_cycles:41};
    vecs[4] = '{words:1,  use_last:1, extra:0, wrap:1000, stuck_at:0,    stuck_pc:32'h8,
                gap:0,  exp_reason:2, exp_cycles:5};

    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; cpu_pc = '0; dump_ready = 1'b0;
    randomize_data();
    step();
    step();
    rst = 1'b0;
    reset_checks("reset");

    // Table-driven scenarios; row 0 carries the add/nop/nop program.
    for (int t = 0; t < 5; t++) begin
      randomize_data();
      if (t == 0) begin
        prog[0] = 32'h0022_1820;
        prog[1] = 32'h0;
        prog[2] = 32'h0;
        regs[1] = 32'd25;
        regs[3] = 32'd50;
      end
      scenario(vecs[t], (t == 0) ? 0 : 1, 1'b0);
    end

    // Reset mid-RUN.
    cur_wrap = 1000; cur_stuck_at = 1000; cur_stuck_pc = 0;
    start_load();
    load_prog(3, 1'b1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cpu_pc = pc_at(k);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    reset_checks("rst_run");

    // Reset mid-DUMP.
    start_load();
    load_prog(3, 1'b1, 0, 0);
    run_prog(2, 8, 1'b0);
    dump_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    dump_ready = 1'b0;
    step();
    rst = 1'b0;
    reset_checks("rst_dump");

    // Restart after reset must load from address 0 again.
    randomize_data();
    scenario(vecs[0], 1, 1'b0);

    // Randomized programs checked against the halt model.
    for (int t = 0; t < 15; t++) begin
      randomize_data();
      v.words    = $urandom_range(1, IMEM_DEPTH);
      v.use_last = (v.words < IMEM_DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      v.extra    = v.use_last ? 0 : $urandom_range(0, 3);
      v.wrap     = $urandom_range(1, 20);
      v.stuck_at = $urandom_range(0, 45);
      v.stuck_pc = 32'($urandom_range(0, 24) * 4);
      v.gap      = $urandom_range(0, 50);
      cur_wrap = v.wrap; cur_stuck_at = v.stuck_at; cur_stuck_pc = v.stuck_pc;
      model_halt(v.words, r_reason, r_cycles);
      v.exp_reason = r_reason;
      v.exp_cycles = r_cycles;
      scenario(v, 1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
